// File: rtl/exe_pkg.sv
// Shared definitions for the multi-cycle execute stage: opcodes, forwarding
// selects, FSM state encoding and NZCV bit positions.
package exe_pkg;

  // Operation codes presented on OPTYPE
  localparam logic [4:0] TYPE_ADD = 5'd0;
  localparam logic [4:0] TYPE_SUB = 5'd1;
  localparam logic [4:0] TYPE_AND = 5'd2;
  localparam logic [4:0] TYPE_OR  = 5'd3;
  localparam logic [4:0] TYPE_EOR = 5'd4;
  localparam logic [4:0] TYPE_BIC = 5'd5;
  localparam logic [4:0] TYPE_NOT = 5'd6;
  localparam logic [4:0] TYPE_NEG = 5'd7;
  localparam logic [4:0] TYPE_MOV = 5'd8;
  localparam logic [4:0] TYPE_LSL = 5'd9;
  localparam logic [4:0] TYPE_LSR = 5'd10;
  localparam logic [4:0] TYPE_ASR = 5'd11;
  localparam logic [4:0] TYPE_ROR = 5'd12;
  localparam logic [4:0] TYPE_MUL = 5'd13;
  localparam logic [4:0] TYPE_BR  = 5'd14;
  localparam logic [4:0] TYPE_BL  = 5'd15;

  // One-hot operand forwarding selects
  localparam logic [3:0] HZ_EXE1 = 4'b0001;
  localparam logic [3:0] HZ_EXE2 = 4'b0010;
  localparam logic [3:0] HZ_MEM  = 4'b0100;
  localparam logic [3:0] HZ_REG  = 4'b1000;

  // NZCV bit positions
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    HOLD = 2'd2
  } exe_state_e;

endpackage

// File: rtl/exe_mul_iter.sv
// Iterative multiplier retiring MUL_R multiplier bits per cycle (LSB first).
// Ports: clk_i/rst_i clock and async active-high reset; start_i loads a_i
// (multiplicand) and b_i (multiplier); done_o is high combinationally during
// the final iteration; product_o carries the low DATA_W bits of a_i*b_i on
// the done cycle and holds it afterwards until the next start.
module exe_mul_iter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned MUL_R  = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              done_o,
  output logic [DATA_W-1:0] product_o
);

  localparam int unsigned ITER = DATA_W / MUL_R;
  localparam int unsigned CW   = (ITER > 1) ? $clog2(ITER) : 1;

  logic [DATA_W-1:0] mcand_q, mplier_q, acc_q, acc_d, partial;
  logic [CW-1:0]     cnt_q;
  logic              busy_q;

  // Partial product for the current multiplier digit
  always_comb begin
    partial = '0;
    for (int unsigned i = 0; i < MUL_R; i++) begin
      if (mplier_q[i]) partial = partial + (mcand_q << i);
    end
    acc_d = acc_q + partial;
  end

  assign done_o    = busy_q && (cnt_q == CW'(ITER - 1));
  assign product_o = busy_q ? acc_d : acc_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start_i) begin
      mcand_q  <= a_i;
      mplier_q <= b_i;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << MUL_R;
      mplier_q <= mplier_q >> MUL_R;
      cnt_q    <= cnt_q + CW'(1);
      if (done_o) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/exe_mc_unit.sv
// Multi-cycle execute stage: forwarding muxes, ALU, barrel shifter, NZCV
// update, iterative multiply and a valid/ready result register.
// Ports: CLK/RST; IN_VALID/IN_READY accept an op described by X, Y, SHAMT,
// OPTYPE, XY_SEL, RD_IN, VALIDRD_IN, NZCV with forwarding EXE_DF1/EXE_DF2/
// MEM_DF selected by HZ_CTRLX/HZ_CTRLY; OUT_VALID/OUT_READY hand Z_RESULT,
// RD_OUT, VALIDRD_OUT and NZCVUPDATE to MEM.
module exe_mc_unit
  import exe_pkg::*;
#(
  parameter  int unsigned DATA_W = 32,
  parameter  int unsigned MUL_R  = 2,
  localparam int unsigned SHW    = $clog2(DATA_W)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [DATA_W-1:0] X,
  input  logic [DATA_W-1:0] Y,
  input  logic [SHW-1:0]    SHAMT,
  input  logic [4:0]        OPTYPE,
  input  logic              XY_SEL,
  input  logic [3:0]        RD_IN,
  input  logic              VALIDRD_IN,
  input  logic [3:0]        NZCV,
  input  logic [DATA_W-1:0] EXE_DF1,
  input  logic [DATA_W-1:0] EXE_DF2,
  input  logic [DATA_W-1:0] MEM_DF,
  input  logic [3:0]        HZ_CTRLX,
  input  logic [3:0]        HZ_CTRLY,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] Z_RESULT,
  output logic [3:0]        RD_OUT,
  output logic              VALIDRD_OUT,
  output logic [3:0]        NZCVUPDATE
);

  localparam int unsigned MSB = DATA_W - 1;

  exe_state_e        state_q, state_d;
  logic [DATA_W-1:0] xs, ys, src, alu_res, ror_res, product;
  logic [DATA_W:0]   add_w, sub_w, neg_w, lsl_w, lsr_w, asr_w;
  logic [3:0]        alu_flags;
  logic              c_new, v_new, passthru;
  logic              out_free, accept, mul_done;
  logic              ld_alu, ld_mul, mul_start;
  logic [3:0]        rd_q;
  logic              vrd_q;
  logic [1:0]        cv_q;
  logic              out_valid_q, vrd_out_q;
  logic [DATA_W-1:0] z_q;
  logic [3:0]        rd_out_q, flags_q;

  // Forwarding muxes; anything other than a one-hot select yields zero
  always_comb begin
    case (HZ_CTRLX)
      HZ_EXE1: xs = EXE_DF1;
      HZ_EXE2: xs = EXE_DF2;
      HZ_MEM:  xs = MEM_DF;
      HZ_REG:  xs = X;
      default: xs = '0;
    endcase
    case (HZ_CTRLY)
      HZ_EXE1: ys = EXE_DF1;
      HZ_EXE2: ys = EXE_DF2;
      HZ_MEM:  ys = MEM_DF;
      HZ_REG:  ys = Y;
      default: ys = '0;
    endcase
    src = XY_SEL ? ys : xs;
  end

  // ALU, shifter and flag generation; the extra bit in each shift carries
  // the last bit shifted out
  always_comb begin
    add_w    = {1'b0, xs} + {1'b0, ys};
    sub_w    = {1'b0, xs} - {1'b0, ys};
    neg_w    = {(DATA_W+1){1'b0}} - {1'b0, ys};
    lsl_w    = {1'b0, src} << SHAMT;
    lsr_w    = {src, 1'b0} >> SHAMT;
    asr_w    = $signed({src, 1'b0}) >>> SHAMT;
    ror_res  = DATA_W'({src, src} >> SHAMT);
    alu_res  = '0;
    c_new    = NZCV[FLAG_C];
    v_new    = NZCV[FLAG_V];
    passthru = 1'b0;
    case (OPTYPE)
      TYPE_ADD: begin
        alu_res = add_w[MSB:0];
        c_new   = add_w[DATA_W];
        v_new   = (xs[MSB] == ys[MSB]) && (add_w[MSB] != xs[MSB]);
      end
      TYPE_SUB: begin
        alu_res = sub_w[MSB:0];
        c_new   = ~sub_w[DATA_W];
        v_new   = (xs[MSB] != ys[MSB]) && (sub_w[MSB] != xs[MSB]);
      end
      TYPE_NEG: begin
        alu_res = neg_w[MSB:0];
        c_new   = ~neg_w[DATA_W];
        v_new   = ys[MSB] && neg_w[MSB];
      end
      TYPE_AND: alu_res = xs & ys;
      TYPE_OR:  alu_res = xs | ys;
      TYPE_EOR: alu_res = xs ^ ys;
      TYPE_BIC: alu_res = xs & ~ys;
      TYPE_NOT: alu_res = ~ys;
      TYPE_MOV: alu_res = src;
      TYPE_LSL: begin
        alu_res = lsl_w[MSB:0];
        if (SHAMT != '0) c_new = lsl_w[DATA_W];
      end
      TYPE_LSR: begin
        alu_res = lsr_w[DATA_W:1];
        if (SHAMT != '0) c_new = lsr_w[0];
      end
      TYPE_ASR: begin
        alu_res = asr_w[DATA_W:1];
        if (SHAMT != '0) c_new = asr_w[0];
      end
      TYPE_ROR: begin
        alu_res = ror_res;
        if (SHAMT != '0) c_new = ror_res[MSB];
      end
      default: passthru = 1'b1;
    endcase
    alu_flags = passthru ? NZCV : {alu_res[MSB], alu_res == '0, c_new, v_new};
  end

  assign out_free = !out_valid_q || OUT_READY;
  assign IN_READY = (state_q == IDLE) && out_free;
  assign accept   = IN_VALID && IN_READY;

  exe_mul_iter #(
    .DATA_W (DATA_W),
    .MUL_R  (MUL_R)
  ) u_mul (
    .clk_i     (CLK),
    .rst_i     (RST),
    .start_i   (mul_start),
    .a_i       (xs),
    .b_i       (ys),
    .done_o    (mul_done),
    .product_o (product)
  );

  // FSM state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state and load strobes
  always_comb begin
    state_d   = state_q;
    ld_alu    = 1'b0;
    ld_mul    = 1'b0;
    mul_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (OPTYPE == TYPE_MUL) begin
            mul_start = 1'b1;
            state_d   = MUL;
          end else begin
            ld_alu = 1'b1;
          end
        end
      end
      MUL: begin
        if (mul_done) begin
          if (out_free) begin
            ld_mul  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_free) begin
          ld_mul  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Multiply side-band captured at acceptance so later inputs cannot leak in
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_q  <= '0;
      vrd_q <= 1'b0;
      cv_q  <= '0;
    end else if (mul_start) begin
      rd_q  <= RD_IN;
      vrd_q <= VALIDRD_IN;
      cv_q  <= NZCV[1:0];
    end
  end

  // Result register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_valid_q <= 1'b0;
      z_q         <= '0;
      rd_out_q    <= '0;
      vrd_out_q   <= 1'b0;
      flags_q     <= '0;
    end else if (ld_alu) begin
      out_valid_q <= 1'b1;
      z_q         <= alu_res;
      rd_out_q    <= RD_IN;
      vrd_out_q   <= VALIDRD_IN;
      flags_q     <= alu_flags;
    end else if (ld_mul) begin
      out_valid_q <= 1'b1;
      z_q         <= product;
      rd_out_q    <= rd_q;
      vrd_out_q   <= vrd_q;
      flags_q     <= {product[MSB], product == '0, cv_q};
    end else if (OUT_READY) begin
      out_valid_q <= 1'b0;
    end
  end

  assign OUT_VALID   = out_valid_q;
  assign Z_RESULT    = z_q;
  assign RD_OUT      = rd_out_q;
  assign VALIDRD_OUT = vrd_out_q;
  assign NZCVUPDATE  = flags_q;

endmodule

// File: tb/tb_exe_mc_unit.sv
// Directed self-checking bench for exe_mc_unit (default parameters).
module tb_exe_mc_unit;
  import exe_pkg::*;

  logic        CLK, RST;
  logic        IN_VALID, IN_READY, XY_SEL, VALIDRD_IN, OUT_VALID, OUT_READY, VALIDRD_OUT;
  logic [31:0] X, Y, EXE_DF1, EXE_DF2, MEM_DF, Z_RESULT;
  logic [4:0]  SHAMT, OPTYPE;
  logic [3:0]  RD_IN, NZCV, HZ_CTRLX, HZ_CTRLY, RD_OUT, NZCVUPDATE;

  int total = 0;
  int bad   = 0;

  exe_mc_unit dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .X(X), .Y(Y), .SHAMT(SHAMT), .OPTYPE(OPTYPE), .XY_SEL(XY_SEL),
    .RD_IN(RD_IN), .VALIDRD_IN(VALIDRD_IN), .NZCV(NZCV),
    .EXE_DF1(EXE_DF1), .EXE_DF2(EXE_DF2), .MEM_DF(MEM_DF),
    .HZ_CTRLX(HZ_CTRLX), .HZ_CTRLY(HZ_CTRLY),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .Z_RESULT(Z_RESULT),
    .RD_OUT(RD_OUT), .VALIDRD_OUT(VALIDRD_OUT), .NZCVUPDATE(NZCVUPDATE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [4:0]  op;
    logic [31:0] x, y;
    logic [4:0]  sh;
    logic        xy;
    logic [3:0]  hzx, hzy, nzcv;
    logic [31:0] ez;
    logic [3:0]  ef;
  } vec_t;

  function automatic vec_t mk(input logic [4:0] op, input logic [31:0] x, y,
                              input logic [4:0] sh, input logic xy,
                              input logic [3:0] hzx, hzy, nzcv,
                              input logic [31:0] ez, input logic [3:0] ef);
    vec_t v;
    v.op = op; v.x = x; v.y = y; v.sh = sh; v.xy = xy;
    v.hzx = hzx; v.hzy = hzy; v.nzcv = nzcv; v.ez = ez; v.ef = ef;
    return v;
  endfunction

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [4:0] op, input logic [31:0] x, y,
                       input logic [4:0] sh, input logic xy,
                       input logic [3:0] hzx, hzy, nzcv);
    OPTYPE = op; X = x; Y = y; SHAMT = sh; XY_SEL = xy;
    HZ_CTRLX = hzx; HZ_CTRLY = hzy; NZCV = nzcv;
  endtask

  task automatic test_reset;
    RST = 1'b1;
    #2;
    total++;
    if ({OUT_VALID, Z_RESULT, RD_OUT, VALIDRD_OUT, NZCVUPDATE} !== 42'd0) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b z=%h rd=%h vrd=%b f=%b, want all zero",
               OUT_VALID, Z_RESULT, RD_OUT, VALIDRD_OUT, NZCVUPDATE);
    end
    tick;
    RST = 1'b0;
    tick;
    total++;
    if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b, want 1 0", IN_READY, OUT_VALID);
    end
  endtask

  task automatic test_add;
    drive(TYPE_ADD, 32'h7FFF_FFFF, 32'h1, 5'd0, 1'b0, HZ_REG, HZ_REG, 4'b0000);
    RD_IN = 4'd3; VALIDRD_IN = 1'b1; IN_VALID = 1'b1;
    tick;
    IN_VALID = 1'b0;
    total++;
    if (OUT_VALID !== 1'b1 || Z_RESULT !== 32'h8000_0000 || NZCVUPDATE !== 4'b1001 ||
        RD_OUT !== 4'd3 || VALIDRD_OUT !== 1'b1) begin
      bad++;
      $display("FAIL add_overflow: got v=%b z=%h f=%b rd=%h vrd=%b, want 1 80000000 1001 3 1",
               OUT_VALID, Z_RESULT, NZCVUPDATE, RD_OUT, VALIDRD_OUT);
    end
    tick;
    total++;
    if (OUT_VALID !== 1'b0) begin
      bad++;
      $display("FAIL add_retire: got out_valid=%b, want 0", OUT_VALID);
    end
  endtask

  task automatic test_sub_fwd;
    drive(TYPE_SUB, 32'h77, 32'h99, 5'd0, 1'b0, HZ_EXE1, HZ_MEM, 4'b0000);
    EXE_DF1 = 32'd5; MEM_DF = 32'd5; EXE_DF2 = 32'd1;
    RD_IN = 4'd9; IN_VALID = 1'b1;
    tick;
    IN_VALID = 1'b0;
    total++;
    if (OUT_VALID !== 1'b1 || Z_RESULT !== 32'd0 || NZCVUPDATE !== 4'b0110) begin
      bad++;
      $display("FAIL sub_forward: got v=%b z=%h f=%b, want 1 00000000 0110",
               OUT_VALID, Z_RESULT, NZCVUPDATE);
    end
    tick;
  endtask

  // Stream of single-cycle ops accepted on consecutive edges
  task automatic test_alu;
    vec_t vecs[$];
    vecs.push_back(mk(TYPE_AND, 32'hF0F0_00FF, 32'h0FF0_0F0F, 0, 0, HZ_REG, HZ_REG, 4'b0011, 32'h00F0_000F, 4'b0011));
    vecs.push_back(mk(TYPE_EOR, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 0, 0, HZ_REG, HZ_REG, 4'b0000, 32'h0, 4'b0100));
    vecs.push_back(mk(TYPE_BIC, 32'hFFFF_0000, 32'h0F0F_0F0F, 0, 0, HZ_REG, HZ_REG, 4'b0001, 32'hF0F0_0000, 4'b1001));
    vecs.push_back(mk(TYPE_OR,  32'h1, 32'h2, 0, 0, HZ_REG, HZ_REG, 4'b1110, 32'h3, 4'b0010));
    vecs.push_back(mk(TYPE_NOT, 32'h5, 32'h0, 0, 0, HZ_REG, HZ_REG, 4'b0000, 32'hFFFF_FFFF, 4'b1000));
    vecs.push_back(mk(TYPE_NEG, 32'h5, 32'h1, 0, 0, HZ_REG, HZ_REG, 4'b0000, 32'hFFFF_FFFF, 4'b1000));
    vecs.push_back(mk(TYPE_NEG, 32'h5, 32'h0, 0, 0, HZ_REG, HZ_REG, 4'b0000, 32'h0, 4'b0110));
    vecs.push_back(mk(TYPE_MOV, 32'h5, 32'h8000_0000, 0, 1, HZ_REG, HZ_REG, 4'b0011, 32'h8000_0000, 4'b1011));
    vecs.push_back(mk(TYPE_ADD, 32'hFFFF_FFFF, 32'h1, 0, 0, HZ_REG, HZ_REG, 4'b0000, 32'h0, 4'b0110));
    vecs.push_back(mk(TYPE_SUB, 32'h3, 32'h5, 0, 0, HZ_REG, HZ_REG, 4'b0011, 32'hFFFF_FFFE, 4'b1000));
    vecs.push_back(mk(TYPE_SUB, 32'h8000_0000, 32'h1, 0, 0, HZ_REG, HZ_REG, 4'b0000, 32'h7FFF_FFFF, 4'b0011));
    vecs.push_back(mk(TYPE_LSR, 32'h3, 32'h0, 1, 0, HZ_REG, HZ_REG, 4'b0000, 32'h1, 4'b0010));
    vecs.push_back(mk(TYPE_LSR, 32'h3, 32'h0, 0, 0, HZ_REG, HZ_REG, 4'b0000, 32'h3, 4'b0000));
    vecs.push_back(mk(TYPE_LSR, 32'h3, 32'h0, 0, 0, HZ_REG, HZ_REG, 4'b0010, 32'h3, 4'b0010));
    vecs.push_back(mk(TYPE_LSL, 32'h8000_0001, 32'h0, 1, 0, HZ_REG, HZ_REG, 4'b0000, 32'h2, 4'b0010));
    vecs.push_back(mk(TYPE_ASR, 32'h8000_0000, 32'h0, 4, 0, HZ_REG, HZ_REG, 4'b0010, 32'hF800_0000, 4'b1000));
    vecs.push_back(mk(TYPE_ROR, 32'h0, 32'h1, 1, 1, HZ_REG, HZ_REG, 4'b0000, 32'h8000_0000, 4'b1010));
    vecs.push_back(mk(TYPE_BR,  32'h5, 32'h6, 0, 0, HZ_REG, HZ_REG, 4'b1010, 32'h0, 4'b1010));
    vecs.push_back(mk(TYPE_ADD, 32'h5, 32'h7, 0, 0, 4'b0011, HZ_REG, 4'b0000, 32'h7, 4'b0000));
    OUT_READY = 1'b1;
    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].sh, vecs[i].xy,
            vecs[i].hzx, vecs[i].hzy, vecs[i].nzcv);
      RD_IN = 4'(i);
      IN_VALID = 1'b1;
      tick;
      total++;
      if (OUT_VALID !== 1'b1 || Z_RESULT !== vecs[i].ez || NZCVUPDATE !== vecs[i].ef ||
          RD_OUT !== 4'(i)) begin
        bad++;
        $display("FAIL alu_vec%0d: got v=%b z=%h f=%b rd=%h, want 1 %h %b %h",
                 i, OUT_VALID, Z_RESULT, NZCVUPDATE, RD_OUT, vecs[i].ez, vecs[i].ef, 4'(i));
      end
    end
    IN_VALID = 1'b0;
    tick;
  endtask

  task automatic test_back_to_back;
    OUT_READY = 1'b0;
    drive(TYPE_ADD, 32'd10, 32'd20, 0, 0, HZ_REG, HZ_REG, 4'b0000);
    RD_IN = 4'd1; IN_VALID = 1'b1;
    tick;
    drive(TYPE_ADD, 32'd100, 32'd200, 0, 0, HZ_REG, HZ_REG, 4'b0000);
    RD_IN = 4'd2;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (IN_READY !== 1'b0 || OUT_VALID !== 1'b1 || Z_RESULT !== 32'd30 || RD_OUT !== 4'd1) begin
        bad++;
        $display("FAIL b2b_hold%0d: got rdy=%b v=%b z=%h rd=%h, want 0 1 0000001e 1",
                 k, IN_READY, OUT_VALID, Z_RESULT, RD_OUT);
      end
      tick;
    end
    OUT_READY = 1'b1;
    #1;
    total++;
    if (IN_READY !== 1'b1) begin
      bad++;
      $display("FAIL b2b_release_ready: got %b, want 1", IN_READY);
    end
    tick;
    IN_VALID = 1'b0;
    total++;
    if (OUT_VALID !== 1'b1 || Z_RESULT !== 32'd300 || RD_OUT !== 4'd2) begin
      bad++;
      $display("FAIL b2b_second: got v=%b z=%h rd=%h, want 1 0000012c 2", OUT_VALID, Z_RESULT, RD_OUT);
    end
    tick;
    total++;
    if (OUT_VALID !== 1'b0) begin
      bad++;
      $display("FAIL b2b_drain: got out_valid=%b, want 0", OUT_VALID);
    end
  endtask

  task automatic test_mul;
    OUT_READY = 1'b1;
    drive(TYPE_MUL, 32'hFFFF_FFFF, 32'd3, 0, 0, HZ_REG, HZ_REG, 4'b0011);
    RD_IN = 4'd7; VALIDRD_IN = 1'b1; IN_VALID = 1'b1;
    tick;
    IN_VALID = 1'b0; NZCV = 4'b1100; RD_IN = 4'd0; X = 32'd0; Y = 32'd0;
    for (int k = 1; k <= 16; k++) begin
      total++;
      if (IN_READY !== 1'b0 || OUT_VALID !== 1'b0) begin
        bad++;
        $display("FAIL mul_busy_c%0d: got rdy=%b v=%b, want 0 0", k, IN_READY, OUT_VALID);
      end
      tick;
    end
    total++;
    if (OUT_VALID !== 1'b1 || Z_RESULT !== 32'hFFFF_FFFD || NZCVUPDATE !== 4'b1011 ||
        RD_OUT !== 4'd7 || IN_READY !== 1'b1) begin
      bad++;
      $display("FAIL mul_result: got v=%b z=%h f=%b rd=%h rdy=%b, want 1 fffffffd 1011 7 1",
               OUT_VALID, Z_RESULT, NZCVUPDATE, RD_OUT, IN_READY);
    end
    tick;
  endtask

  // Multiplies with a bounded wait for completion
  task automatic test_mul_values;
    logic [31:0] ax[2], by[2], ez[2];
    logic [3:0]  ef[2];
    ax[0] = 32'd7;       by[0] = 32'd6;       ez[0] = 32'd42; ef[0] = 4'b0000;
    ax[1] = 32'h1_0000;  by[1] = 32'h1_0000;  ez[1] = 32'd0;  ef[1] = 4'b0101;
    for (int t = 0; t < 2; t++) begin
      int n;
      drive(TYPE_MUL, ax[t], by[t], 0, 0, HZ_REG, HZ_REG, (t == 1) ? 4'b1001 : 4'b0000);
      IN_VALID = 1'b1;
      tick;
      IN_VALID = 1'b0;
      n = 0;
      while (OUT_VALID !== 1'b1 && n < 40) begin
        tick;
        n++;
      end
      total++;
      if (OUT_VALID !== 1'b1 || Z_RESULT !== ez[t] || NZCVUPDATE !== ef[t]) begin
        bad++;
        $display("FAIL mul_val%0d: got v=%b z=%h f=%b after %0d cycles, want 1 %h %b",
                 t, OUT_VALID, Z_RESULT, NZCVUPDATE, n, ez[t], ef[t]);
      end
      tick;
    end
  endtask

  task automatic test_reset_mid_mul;
    int stale;
    OUT_READY = 1'b1;
    drive(TYPE_MUL, 32'd9, 32'd9, 0, 0, HZ_REG, HZ_REG, 4'b1111);
    RD_IN = 4'd5; IN_VALID = 1'b1;
    tick;
    IN_VALID = 1'b0;
    repeat (4) tick;
    RST = 1'b1;
    #1;
    total++;
    if ({OUT_VALID, Z_RESULT, RD_OUT, VALIDRD_OUT, NZCVUPDATE} !== 42'd0) begin
      bad++;
      $display("FAIL rst_mid_mul: got v=%b z=%h rd=%h vrd=%b f=%b, want all zero",
               OUT_VALID, Z_RESULT, RD_OUT, VALIDRD_OUT, NZCVUPDATE);
    end
    tick;
    RST = 1'b0;
    #1;
    total++;
    if (IN_READY !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_ready: got %b, want 1", IN_READY);
    end
    stale = 0;
    for (int k = 0; k < 25; k++) begin
      tick;
      if (OUT_VALID !== 1'b0) stale++;
    end
    total++;
    if (stale != 0) begin
      bad++;
      $display("FAIL rst_mid_stale: out_valid high in %0d cycles, want 0", stale);
    end
  endtask

  initial begin
    RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b1;
    X = '0; Y = '0; SHAMT = '0; OPTYPE = TYPE_ADD; XY_SEL = 1'b0;
    RD_IN = '0; VALIDRD_IN = 1'b0; NZCV = '0;
    EXE_DF1 = '0; EXE_DF2 = '0; MEM_DF = '0;
    HZ_CTRLX = HZ_REG; HZ_CTRLY = HZ_REG;
    test_reset;
    test_add;
    test_sub_fwd;
    test_alu;
    test_back_to_back;
    test_mul;
    test_mul_values;
    test_reset_mid_mul;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
